// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounced buttons -> round-robin press events over valid/ready; define BTN_LONG_PRESS_EN for long-press events
module btn_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int DB_CNT = 1000,
  parameter int LP_CNT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_id,
  output logic             evt_long,
  output logic [N_BTN-1:0] pending,
  output logic             overrun,
  input  logic             clr_overrun
);
  localparam int DW = $clog2(DB_CNT);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_nx;
  logic [N_BTN-1:0] s1, s2, stable, rise, grant, req;
  logic [N_BTN-1:0][DW-1:0] cnt;
  logic [2:0] rr, id_q, g_idx;
  logic g_found, use_long;
  int idx;
  // two-flop synchronizer on the raw button levels
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  // debounce: accept a new level once it has differed from stable for DB_CNT cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++)
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DB_CNT - 1)) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // rising edge of stable, seen one cycle early so pending sets with stable
  always_comb
    for (int i = 0; i < N_BTN; i++)
      rise[i] = s2[i] & ~stable[i] & (cnt[i] == DW'(DB_CNT - 1));
`ifdef BTN_LONG_PRESS_EN
  localparam int LW = $clog2(LP_CNT);
  logic [N_BTN-1:0][LW-1:0] lp_cnt;
  logic [N_BTN-1:0] lp_done, lp_hit, long_pending, long_grant;
  logic long_q;
  // hold counters: one long event per press, rearmed when the button is released
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lp_cnt <= '0;
      lp_done <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++)
        if (!stable[i]) begin
          lp_cnt[i] <= '0;
          lp_done[i] <= 1'b0;
        end else if (!lp_done[i]) begin
          if (lp_cnt[i] == LW'(LP_CNT - 1)) lp_done[i] <= 1'b1;
          else lp_cnt[i] <= lp_cnt[i] + 1'b1;
        end
    end
  // long-press hit strobe
  always_comb
    for (int i = 0; i < N_BTN; i++)
      lp_hit[i] = stable[i] & ~lp_done[i] & (lp_cnt[i] == LW'(LP_CNT - 1));
  // long pending flags, a new hit wins over a same-cycle grant clear
  always_ff @(posedge clk or posedge rst)
    if (rst) long_pending <= '0;
    else long_pending <= (long_pending & ~long_grant) | lp_hit;
  // remember the kind of the granted event for the offer
  always_ff @(posedge clk or posedge rst)
    if (rst) long_q <= 1'b0;
    else if (state == IDLE && g_found) long_q <= use_long;
  assign use_long = |long_pending;
  assign long_grant = (state == IDLE && g_found && use_long) ? N_BTN'(1) << g_idx : '0;
  assign evt_long = evt_valid & long_q;
  assign req = use_long ? long_pending : pending;
`else
  assign use_long = 1'b0;
  assign evt_long = 1'b0;
  assign req = pending;
`endif
  // round-robin scan: first request at or after rr, wrapping
  always_comb begin
    g_found = 1'b0;
    g_idx = '0;
    idx = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(rr) + k >= N_BTN) ? int'(rr) + k - N_BTN : int'(rr) + k;
      if (!g_found && req[idx]) begin
        g_found = 1'b1;
        g_idx = 3'(idx);
      end
    end
  end
  assign grant = (state == IDLE && g_found && !use_long) ? N_BTN'(1) << g_idx : '0;
  // short pending flags; a new press wins over a same-cycle grant, a press on an ungranted pending bit is an overrun
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | rise;
      if (|(rise & pending & ~grant)) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  // grant capture and round-robin pointer advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_q <= '0;
      rr <= '0;
    end else if (state == IDLE && g_found) begin
      id_q <= g_idx;
      rr <= (g_idx == 3'(N_BTN - 1)) ? 3'd0 : g_idx + 3'd1;
    end
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // FSM next state: offer after a grant, hold the offer until accepted
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (g_found ? OFFER : IDLE) : (evt_ready ? IDLE : OFFER);
  end
  assign evt_valid = (state == OFFER);
  assign evt_id = evt_valid ? id_q : 3'd0;
endmodule
